// File: rtl/demux_1ton_stream.sv
// demux_1ton_stream: registered 1:N stream demultiplexer with valid/ready
// handshake. Each input word goes to one channel, chosen either by an explicit
// select or by a round-robin pointer. Each channel holds its word in a
// one-entry register until the downstream side takes it.
module demux_1ton_stream #(
  parameter int WIDTH = 1,
  parameter int N_OUT = 2,
  localparam int SEL_W = $clog2(N_OUT)
) (
  input  logic                   inClk,
  input  logic                   inReset,
  input  logic                   inClear,
  input  logic                   inAuto,
  input  logic [SEL_W-1:0]       inSel,
  input  logic [WIDTH-1:0]       inData,
  input  logic                   inValid,
  output logic                   outReady,
  output logic [N_OUT*WIDTH-1:0] outData,
  output logic [N_OUT-1:0]       outValid,
  input  logic [N_OUT-1:0]       inReady,
  output logic [SEL_W-1:0]       outPtr,
  output logic                   outErr
);

  // One extra bit so that N_OUT itself can be represented when N_OUT is a power of 2.
  localparam logic [SEL_W:0]   N_OUT_C = (SEL_W + 1)'(N_OUT);
  localparam logic [SEL_W-1:0] PTR_MAX = SEL_W'(N_OUT - 1);

  logic [SEL_W-1:0] target;
  logic             targetInRange;
  logic [N_OUT-1:0] targetHit;
  logic [N_OUT-1:0] chReady;
  logic             accept;
  logic [SEL_W-1:0] ptrReg;
  logic [SEL_W-1:0] ptrNext;
  logic             errReg;
  logic             errNext;
  logic [N_OUT-1:0] validReg;
  logic [WIDTH-1:0] dataReg [N_OUT];

  assign target        = inAuto ? ptrReg : inSel;
  assign targetInRange = ({1'b0, target} < N_OUT_C);

  // The channel decode is one-hot, so the target's ready can be picked without
  // a variable index. A channel can take a new word if it is empty or is being
  // drained in this same cycle.
  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : gChDecode
      assign targetHit[gi] = (target == SEL_W'(gi));
      assign chReady[gi]   = ~validReg[gi] | inReady[gi];
    end
  endgenerate

  // Handshake: clear blocks input. An out-of-range target always accepts
  // the word and then drops it.
  always_comb begin
    outReady = 1'b0;
    if (inClear) begin
      outReady = 1'b0;
    end else if (!targetInRange) begin
      outReady = 1'b1;
    end else begin
      outReady = |(chReady & targetHit);
    end
  end

  assign accept = inValid & outReady;

  // Pointer and sticky error next-state. The pointer moves only on an accepted
  // transfer in round-robin mode. In that mode the target is always in range.
  always_comb begin
    ptrNext = ptrReg;
    errNext = errReg;
    if (inClear) begin
      ptrNext = '0;
      errNext = 1'b0;
    end else if (accept) begin
      if (inAuto) begin
        ptrNext = (ptrReg == PTR_MAX) ? '0 : ptrReg + SEL_W'(1);
      end
      if (!targetInRange) begin
        errNext = 1'b1;
      end
    end
  end

  // Pointer and error registers.
  always_ff @(posedge inClk or posedge inReset) begin
    if (inReset) begin
      ptrReg <= '0;
      errReg <= 1'b0;
    end else begin
      ptrReg <= ptrNext;
      errReg <= errNext;
    end
  end

  // Per-channel holding registers. A load takes priority over a drain, so a
  // word that arrives while the old one is being taken stays valid. The data
  // is kept after the word is taken.
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : gChannel
      logic chLoad;
      assign chLoad = accept & targetInRange & targetHit[gi];

      // Channel gi state update.
      always_ff @(posedge inClk or posedge inReset) begin
        if (inReset) begin
          validReg[gi] <= 1'b0;
          dataReg[gi]  <= '0;
        end else if (inClear) begin
          validReg[gi] <= 1'b0;
        end else if (chLoad) begin
          validReg[gi] <= 1'b1;
          dataReg[gi]  <= inData;
        end else begin
          validReg[gi] <= validReg[gi] & ~inReady[gi];
        end
      end

      assign outData[gi*WIDTH +: WIDTH] = dataReg[gi];
    end
  endgenerate

  assign outValid = validReg;
  assign outPtr   = ptrReg;
  assign outErr   = errReg;

endmodule

// File: tb/tb_demux_1ton_stream.sv
// Directed bench for demux_1ton_stream. One 4-channel instance is used for the
// select-routing vectors. One 3-channel instance covers round-robin,
// backpressure, out-of-range, clear and reset.
module tb_demux_1ton_stream;

  logic inClk = 1'b0;
  logic rst   = 1'b0;
  always #5 inClk = ~inClk;

  // 4-channel instance
  logic        clear4 = 0, auto4 = 0, valid4 = 0;
  logic [1:0]  sel4 = 0;
  logic [7:0]  data4 = 0;
  logic        oready4;
  logic [31:0] odata4;
  logic [3:0]  ovalid4;
  logic [3:0]  iready4 = 0;
  logic [1:0]  ptr4;
  logic        err4;

  // 3-channel instance
  logic        clear3 = 0, auto3 = 0, valid3 = 0;
  logic [1:0]  sel3 = 0;
  logic [7:0]  data3 = 0;
  logic        oready3;
  logic [23:0] odata3;
  logic [2:0]  ovalid3;
  logic [2:0]  iready3 = 0;
  logic [1:0]  ptr3;
  logic        err3;

  demux_1ton_stream #(.WIDTH(8), .N_OUT(4)) dut4 (
    .inClk(inClk), .inReset(rst), .inClear(clear4), .inAuto(auto4),
    .inSel(sel4), .inData(data4), .inValid(valid4), .outReady(oready4),
    .outData(odata4), .outValid(ovalid4), .inReady(iready4),
    .outPtr(ptr4), .outErr(err4)
  );

  demux_1ton_stream #(.WIDTH(8), .N_OUT(3)) dut3 (
    .inClk(inClk), .inReset(rst), .inClear(clear3), .inAuto(auto3),
    .inSel(sel3), .inData(data3), .inValid(valid3), .outReady(oready3),
    .outData(odata3), .outValid(ovalid3), .inReady(iready3),
    .outPtr(ptr3), .outErr(err3)
  );

  int checkCount = 0;
  int errorCount = 0;

  task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end else begin
      $display("ok   %s: %0h", tag, act);
    end
  endtask

  // Inputs change 1 time unit after the rising edge. Registered outputs are
  // sampled right after that.
  task automatic tick;
    @(posedge inClk);
    #1;
  endtask

  initial begin
    // T1: reset held with a valid input present
    rst = 1; valid3 = 1; data3 = 8'hFF; valid4 = 1; data4 = 8'hEE;
    tick; tick;
    #1;
    checkVal("t1.valid3", 32'(ovalid3), 32'd0);
    checkVal("t1.ptr3",   32'(ptr3),    32'd0);
    checkVal("t1.err3",   32'(err3),    32'd0);
    checkVal("t1.ready3", 32'(oready3), 32'd1);
    checkVal("t1.data3",  32'(odata3),  32'd0);
    checkVal("t1.data4",  odata4,       32'd0);
    valid3 = 0; valid4 = 0;
    rst = 0;
    tick;

    // T2: select routing on the 4-channel instance
    auto4 = 0; iready4 = 4'hF;
    valid4 = 1; data4 = 8'hA5; sel4 = 2;
    #1 checkVal("t2.ready", 32'(oready4), 32'd1);
    tick;
    checkVal("t2.ch2", 32'(odata4[23:16]), 32'hA5);
    checkVal("t2.valid.a", 32'(ovalid4), 32'b0100);
    data4 = 8'h3C; sel4 = 0;
    tick;
    checkVal("t2.valid.b", 32'(ovalid4), 32'b0001);
    checkVal("t2.ch0", 32'(odata4[7:0]), 32'h3C);
    checkVal("t2.ch2.kept", 32'(odata4[23:16]), 32'hA5);
    valid4 = 0;
    tick;
    checkVal("t2.drained", 32'(ovalid4), 32'd0);

    // T3: round-robin on the 3-channel instance, back-to-back words
    auto3 = 1; iready3 = 3'b111; valid3 = 1;
    for (int i = 0; i < 6; i++) begin
      data3 = 8'(i);
      #1;
      checkVal($sformatf("t3.ready.%0d", i), 32'(oready3), 32'd1);
      checkVal($sformatf("t3.ptr.%0d", i), 32'(ptr3), 32'(i % 3));
      tick;
      checkVal($sformatf("t3.valid.%0d", i), 32'(ovalid3), 32'(1 << (i % 3)));
      checkVal($sformatf("t3.data.%0d", i), 32'(odata3[(i % 3) * 8 +: 8]), 32'(i));
    end
    valid3 = 0;
    #1 checkVal("t3.ptr.end", 32'(ptr3), 32'd0);
    tick;

    // T4: backpressure with target 1 full. The pointer is kept across mode switches.
    iready3 = 3'b000;
    valid3 = 1; auto3 = 1; data3 = 8'h20;       // round-robin puts this in ch0, ptr becomes 1
    tick;
    auto3 = 0; sel3 = 1; data3 = 8'h21;         // select mode puts this in ch1, ptr stays
    tick;
    checkVal("t4.ptr.sel", 32'(ptr3), 32'd1);
    auto3 = 1; data3 = 8'h22;                   // target is ptr = 1, ch1 full, not drained
    #1 checkVal("t4.stall", 32'(oready3), 32'd0);
    tick;
    checkVal("t4.ptr.hold", 32'(ptr3), 32'd1);
    checkVal("t4.ch1.old", 32'(odata3[15:8]), 32'h21);
    checkVal("t4.valid.hold", 32'(ovalid3), 32'b011);
    iready3 = 3'b010;
    #1 checkVal("t4.ready.drain", 32'(oready3), 32'd1);
    tick;
    checkVal("t4.ch1.new", 32'(odata3[15:8]), 32'h22);
    checkVal("t4.valid.stay", 32'(ovalid3), 32'b011);
    checkVal("t4.ptr.adv", 32'(ptr3), 32'd2);
    valid3 = 0; iready3 = 3'b111;
    tick;
    checkVal("t4.drained", 32'(ovalid3), 32'd0);

    // T5: select 3 is out of range for N_OUT=3
    iready3 = 3'b000;
    auto3 = 0; sel3 = 3; valid3 = 1; data3 = 8'h77;
    #1 checkVal("t5.ready", 32'(oready3), 32'd1);
    tick;
    valid3 = 0;
    checkVal("t5.err", 32'(err3), 32'd1);
    checkVal("t5.valid", 32'(ovalid3), 32'd0);
    checkVal("t5.ptr", 32'(ptr3), 32'd2);
    checkVal("t5.data", 32'(odata3), 32'h052220);
    tick;
    checkVal("t5.err.sticky", 32'(err3), 32'd1);
    clear3 = 1;
    #1 checkVal("t5.clear.ready", 32'(oready3), 32'd0);
    tick;
    clear3 = 0;
    checkVal("t5.err.clr", 32'(err3), 32'd0);
    checkVal("t5.ptr.clr", 32'(ptr3), 32'd0);

    // T6: clear while ch0 and ch2 are full and ptr = 2
    auto3 = 1; valid3 = 1; data3 = 8'h30;       // ch0
    tick;
    data3 = 8'h31;                              // ch1, ptr becomes 2
    tick;
    valid3 = 0; iready3 = 3'b010;               // drain ch1
    tick;
    iready3 = 3'b000; auto3 = 0; sel3 = 2; valid3 = 1; data3 = 8'h32;
    tick;
    checkVal("t6.setup.valid", 32'(ovalid3), 32'b101);
    checkVal("t6.setup.ptr", 32'(ptr3), 32'd2);
    clear3 = 1; auto3 = 1; data3 = 8'h99;       // valid input stays high during the clear
    #1 checkVal("t6.clear.ready", 32'(oready3), 32'd0);
    tick;
    clear3 = 0; valid3 = 0;
    checkVal("t6.clear.valid", 32'(ovalid3), 32'd0);
    checkVal("t6.clear.ptr", 32'(ptr3), 32'd0);
    checkVal("t6.clear.data", 32'(odata3), 32'h323130);
    // Reset in the middle of a transfer
    auto3 = 0; sel3 = 0; valid3 = 1; data3 = 8'h40;
    tick;
    checkVal("t6.reload", 32'(ovalid3), 32'b001);
    #2 rst = 1;
    #1;
    checkVal("t6.rst.valid", 32'(ovalid3), 32'd0);
    checkVal("t6.rst.data", 32'(odata3), 32'd0);
    checkVal("t6.rst.ptr", 32'(ptr3), 32'd0);
    valid3 = 0;
    #1 rst = 0;
    tick;
    checkVal("t6.post.valid", 32'(ovalid3), 32'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
